clink_tx: RTL and testbench

- Transmit end of the CLINK link: accepts wide UMI packets over valid/ready and serializes each into DW/IOW lane beats on the PHY side.
- Paces traffic with a credit counter that mirrors free entries in the far-end receive FIFO. The far end returns one credit per packet it drains.
- Sits between the core-side UMI port and the lane driver, on the core clock.

---
 rtl/clink_pkg.sv | 22 ++
 rtl/clink_credit_ctr.sv | 35 +++
 rtl/clink_tx.sv | 111 +++++++++++
 tb/tb_clink_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/clink_pkg.sv
// Shared CLINK constants and state encoding, used by both link ends.
package clink_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } clink_state_t;

  function automatic int nbeats(input int dw, input int iow);
    return dw / iow;
  endfunction

  // Beat counter width; never narrower than one bit so NBEATS==1 still has a counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int credit_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/clink_credit_ctr.sv
// Saturating credit counter mirroring free far-end FIFO entries, with sticky
// overflow error for returns that arrive while already full.
module clink_credit_ctr
  import clink_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = credit_w(CREDITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          consume,
  input  logic          ret,
  output logic [CW-1:0] credits,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= FULL;
      err     <= 1'b0;
    end else if (consume && !ret) begin
      credits <= credits - CW'(1);
    end else if (ret && !consume) begin
      // A return with nothing outstanding means the far end is out of sync.
      if (credits == FULL) begin
        err <= 1'b1;
      end else begin
        credits <= credits + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clink_tx.sv
// CLINK transmit side: holds one UMI packet and serializes it LSB slice first
// onto the lane, gated by far-end FIFO credits.
module clink_tx
  import clink_pkg::*;
#(
  parameter     TARGET   = "DEFAULT",
  parameter int DW       = 256,
  parameter int IOW      = 64,
  parameter int CREDITS  = 4,
  parameter int NBEATS   = nbeats(DW, IOW),
  parameter int CNT_W    = cnt_w(NBEATS),
  parameter int CREDIT_W = credit_w(CREDITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                umi_in_valid,
  input  logic [DW-1:0]       umi_in_data,
  output logic                umi_in_ready,
  output logic                phy_txvalid,
  output logic [IOW-1:0]      phy_txdata,
  output logic                phy_txlast,
  input  logic                phy_txready,
  input  logic                credit_return,
  output logic [CREDIT_W-1:0] credits,
  output logic                credit_err,
  output logic                busy
);

  clink_state_t     state_reg, state_next;
  logic [DW-1:0]    hold_reg;
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic             last_beat;
  logic             accept;
  logic             beat_done;
  logic [IOW-1:0]   beat_data;
  logic [IOW-1:0]   beats [NBEATS];

  assign last_beat = (beat_reg == CNT_W'(NBEATS - 1));
  assign beat_done = (state_reg == SEND) && phy_txready;

  // A same-cycle credit return can fund this accept even at zero credits.
  assign umi_in_ready = !reset && ((credits != '0) || credit_return) &&
                        ((state_reg == IDLE) || (beat_done && last_beat));
  assign accept = umi_in_valid && umi_in_ready;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    if (accept) begin
      state_next = SEND;
      beat_next  = '0;
    end else if (beat_done) begin
      if (last_beat) begin
        state_next = IDLE;
      end else begin
        beat_next = beat_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        hold_reg <= umi_in_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_slice
      assign beats[gi] = hold_reg[gi*IOW +: IOW];
    end

    if (TARGET == "DEFAULT") begin : g_mux
      assign beat_data = beats[beat_reg];
    end else begin : g_andor
      // One-hot AND-OR select; maps well where wide muxes are costly.
      always_comb begin
        beat_data = '0;
        for (int i = 0; i < NBEATS; i++) begin
          if (beat_reg == CNT_W'(i)) beat_data = beat_data | beats[i];
        end
      end
    end
  endgenerate

  assign phy_txvalid = (state_reg == SEND);
  assign phy_txdata  = phy_txvalid ? beat_data : '0;
  assign phy_txlast  = phy_txvalid && last_beat;
  assign busy        = (state_reg == SEND);

  clink_credit_ctr #(
    .CREDITS (CREDITS),
    .CW      (CREDIT_W)
  ) u_credit_ctr (
    .clk     (clk),
    .reset   (reset),
    .consume (accept),
    .ret     (credit_return),
    .credits (credits),
    .err     (credit_err)
  );

endmodule

// File: tb/tb_clink_tx.sv
// Randomized and directed bench for clink_tx against a queue-of-beats reference model.
module tb_clink_tx;

  localparam int DW = 256;
  localparam int IOW = 64;
  localparam int CREDITS = 4;
  localparam int NB = DW / IOW;

  logic           clk;
  logic           reset;
  logic           umi_in_valid;
  logic [DW-1:0]  umi_in_data;
  logic           umi_in_ready;
  logic           phy_txvalid;
  logic [IOW-1:0] phy_txdata;
  logic           phy_txlast;
  logic           phy_txready;
  logic           credit_return;
  logic [2:0]     credits;
  logic           credit_err;
  logic           busy;

  clink_tx #(.TARGET("DEFAULT"), .DW(DW), .IOW(IOW), .CREDITS(CREDITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .umi_in_valid  (umi_in_valid),
    .umi_in_data   (umi_in_data),
    .umi_in_ready  (umi_in_ready),
    .phy_txvalid   (phy_txvalid),
    .phy_txdata    (phy_txdata),
    .phy_txlast    (phy_txlast),
    .phy_txready   (phy_txready),
    .credit_return (credit_return),
    .credits       (credits),
    .credit_err    (credit_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats still owed on the lane, credits, sticky error.
  logic [IOW-1:0] q[$];
  int             mcred;
  bit             merr;
  int             checks;
  int             failures;

  task automatic chk(input string tag, input logic [IOW-1:0] got, input logic [IOW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] r256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive at negedge, check before posedge, advance model at posedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit tr, input bit rt, output bit acc);
    bit er;
    bit pop;
    @(negedge clk);
    umi_in_valid  = v;
    umi_in_data   = d;
    phy_txready   = tr;
    credit_return = rt;
    #2;
    er = (mcred != 0 || rt) && (q.size() == 0 || (q.size() == 1 && tr));
    chk("ready", umi_in_ready, er);
    chk("txvalid", phy_txvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("txdata", phy_txdata, q[0]);
      chk("txlast", phy_txlast, q.size() == 1);
    end
    chk("credits", credits, mcred);
    chk("credit_err", credit_err, merr);
    chk("busy", busy, q.size() != 0);
    acc = v && er;
    pop = (q.size() != 0) && tr;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) for (int i = 0; i < NB; i++) q.push_back(d[i*IOW +: IOW]);
    mcred = mcred - int'(acc) + int'(rt);
    if (mcred > CREDITS) begin
      mcred = CREDITS;
      merr  = 1'b1;
    end
    if (acc) $display("tx accept data=%h credits=%0d", d, mcred);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, umi_in_ready, 1'b0);
    chk({tag, "_txvalid"}, phy_txvalid, 1'b0);
    chk({tag, "_txdata"}, phy_txdata, '0);
    chk({tag, "_txlast"}, phy_txlast, 1'b0);
    chk({tag, "_credits"}, credits, CREDITS);
    chk({tag, "_err"}, credit_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    bit              a;
    bit              pulsed;
    logic [DW-1:0]   pkt;
    logic [DW-1:0]   cur;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    umi_in_valid = 1'b0;
    umi_in_data = '0;
    phy_txready = 1'b0;
    credit_return = 1'b0;
    q.delete();
    mcred = CREDITS;
    merr = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b0;

    // Single packet, LSB slice first.
    pkt = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    cyc(1, pkt, 1, 0, a);
    chk("t1_accept", a, 1'b1);
    for (int i = 0; i < NB + 1; i++) cyc(0, r256(), 1, 0, a);
    chk("t1_credits", mcred, 3);

    // Refill, then back-to-back until credits run out; one return on a final beat at zero credits.
    while (mcred < CREDITS) cyc(0, '0, 1, 1, a);
    cur = r256();
    pulsed = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (!pulsed && mcred == 0 && q.size() == 1) begin
        cyc(1, cur, 1, 1, a);
        chk("t3_accept_on_return", a, 1'b1);
        pulsed = 1'b1;
      end else begin
        cyc(1, cur, 1, 0, a);
      end
      if (a) cur = r256();
    end
    chk("t2_credits_zero", mcred, 0);
    for (int i = 0; i < NB; i++) cyc(0, '0, 1, 0, a);

    // Stall three cycles on beat 2.
    while (mcred < CREDITS) cyc(0, '0, 1, 1, a);
    cyc(1, pkt, 1, 0, a);
    cyc(0, '0, 1, 0, a);
    cyc(0, '0, 1, 0, a);
    for (int i = 0; i < 3; i++) cyc(0, r256(), 0, 0, a);
    cyc(0, '0, 1, 0, a);
    cyc(0, '0, 1, 0, a);
    cyc(0, '0, 1, 0, a);

    // Random traffic with legitimate returns only.
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 3) != 0, r256(), $urandom_range(0, 3) != 0,
          (mcred < CREDITS) && ($urandom_range(0, 2) == 0), a);
    end
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, mcred < CREDITS, a);

    // Spurious return at full credits: saturates and latches the error.
    chk("t5_full", mcred, CREDITS);
    cyc(0, '0, 1, 1, a);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, a);
    chk("t5_err_model", merr, 1'b1);

    // Reset in the middle of beat 1.
    cyc(1, r256(), 1, 0, a);
    cyc(0, '0, 1, 0, a);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    q.delete();
    mcred = CREDITS;
    merr = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    reset = 1'b0;
    cyc(1, pkt, 1, 0, a);
    chk("t6_accept", a, 1'b1);
    for (int i = 0; i < NB + 1; i++) cyc(0, '0, 1, 0, a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
